// File: rtl/ysyx_2022040010_dmem_resp.sv
// ysyx_2022040010_dmem_resp: MEM-stage data-memory responder with fixed-latency byte RAM.
// Define YSYX_DMEM_ERR_EN to report misaligned/out-of-range accesses on rsp_err.
module ysyx_2022040010_dmem_resp #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [63:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int NB = DATA_W / 8;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY == 0 ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d, nbytes;
    logic              we_q, we_d, uns_q, uns_d, fault_q, fault_d, err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d, in_addr, low_mask, base;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, dword, raw, load_val;
    logic              in_fault, idle, commit, sign;
    logic [7:0]        mem [2**ADDR_W];

    assign idle     = state_q == IDLE;
    assign commit   = (idle && req_valid && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd0);
    assign low_mask = ADDR_W'((4'd1 << req_size) - 4'd1);

`ifdef YSYX_DMEM_ERR_EN
    assign in_addr  = req_addr[ADDR_W-1:0];
    assign in_fault = (|(in_addr & low_mask)) || (|req_addr[63:ADDR_W]);
`else
    logic unused_hi;
    assign unused_hi = |req_addr[63:ADDR_W];
    assign in_addr   = req_addr[ADDR_W-1:0] & ~low_mask;
    assign in_fault  = 1'b0;
`endif

    // Request fields pass through while idle so a zero-latency commit sees them directly.
    always_comb begin
        we_d    = idle ? req_we : we_q;
        uns_d   = idle ? req_unsigned : uns_q;
        size_d  = idle ? req_size : size_q;
        addr_d  = idle ? in_addr : addr_q;
        wdata_d = idle ? req_wdata : wdata_q;
        fault_d = idle ? in_fault : fault_q;
        base    = {addr_d[ADDR_W-1:3], 3'b000};
        for (int i = 0; i < NB; i++) dword[8*i +: 8] = mem[base + ADDR_W'(i)];
        raw      = dword >> {addr_d[2:0], 3'b000};
        sign     = !uns_d && (size_d == 2'd0 ? raw[7] : size_d == 2'd1 ? raw[15] : raw[31]);
        load_val = size_d == 2'd0 ? {{(DATA_W-8){sign}}, raw[7:0]} :
                   size_d == 2'd1 ? {{(DATA_W-16){sign}}, raw[15:0]} :
                   size_d == 2'd2 ? {{(DATA_W-32){sign}}, raw[31:0]} : raw;
        nbytes   = 4'd1 << size_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = LATENCY == 0 ? RESP : WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rdata_d = (we_d || fault_d) ? '0 : load_val;
            err_d   = fault_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Accesses are aligned (or faulted), so the written bytes never leave one dword.
    always_ff @(posedge clk) begin
        if (commit && we_d && !fault_d && !rst)
            for (int i = 0; i < NB; i++)
                if (4'(i) < nbytes) mem[addr_d + ADDR_W'(i)] <= wdata_d[8*i +: 8];
    end

    assign req_ready = idle;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_ysyx_2022040010_dmem_resp.sv
// tb_ysyx_2022040010_dmem_resp: scoreboard bench for the dmem responder (LATENCY 2 and 0 instances).
module tb_ysyx_2022040010_dmem_resp;
    logic        clk = 1'b0, rst = 1'b1;
    logic        rv0 = 1'b0, rv1 = 1'b0, rsp_ready = 1'b1;
    logic        we = 1'b0, uns = 1'b0;
    logic [63:0] addr = '0, wdata = '0;
    logic [1:0]  size = '0;
    logic        rdy0, rdy1, vld0, vld1, err0, err1;
    logic [63:0] rd0, rd1;
    int          cyc = 0, checks = 0, fails = 0;

    typedef struct {logic [63:0] rd; logic err; int acc; bit lat;} exp_t;
    exp_t q0[$], q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_2022040010_dmem_resp #(.ADDR_W(12), .DATA_W(64), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_we(we),
        .req_addr(addr), .req_size(size), .req_unsigned(uns), .req_wdata(wdata),
        .rsp_valid(vld0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err0));

    ysyx_2022040010_dmem_resp #(.ADDR_W(12), .DATA_W(64), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_we(we),
        .req_addr(addr), .req_size(size), .req_unsigned(uns), .req_wdata(wdata),
        .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(err1));

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && vld0 && rsp_ready) begin
            if (q0.size() == 0) chk("unexpected_rsp0", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("rdata0", rd0, e0.rd);
                chk("err0", {63'd0, err0}, {63'd0, e0.err});
                if (e0.lat) chk("latency0", 64'(cyc - e0.acc), 2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && vld1 && rsp_ready) begin
            if (q1.size() == 0) chk("unexpected_rsp1", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("rdata1", rd1, e1.rd);
                chk("err1", {63'd0, err1}, {63'd0, e1.err});
                if (e1.lat) chk("latency1", 64'(cyc - e1.acc), 0);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int d, input logic w, input logic [63:0] a, input logic [1:0] s,
                         input logic u, input logic [63:0] wd, input logic [63:0] er,
                         input logic ee, input bit lat, output int acc);
        int n = 0;
        we = w; addr = a; size = s; uns = u; wdata = wd;
        if (d == 0) rv0 = 1'b1; else rv1 = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!(d == 0 ? rdy0 : rdy1) && n < 50);
        if (!(d == 0 ? rdy0 : rdy1)) chk("accept_timeout", 0, 1);
        acc = cyc + 1;
        if (d == 0) q0.push_back('{er, ee, acc, lat});
        else q1.push_back('{er, ee, acc, lat});
        @(posedge clk);
        #1;
        rv0 = 1'b0;
        rv1 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q0.size() + q1.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a1, a2, a3, n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready0", {63'd0, rdy0}, 1);
        chk("rst_rsp_valid0", {63'd0, vld0}, 0);
        chk("rst_rdata0", rd0, 0);
        chk("rst_err0", {63'd0, err0}, 0);
        chk("rst_req_ready1", {63'd0, rdy1}, 1);
        chk("rst_rsp_valid1", {63'd0, vld1}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // dword store/load with latency checks
        issue(0, 1, 64'h10, 2'd3, 0, 64'h1122334455667788, 64'h0, 0, 1, a1);
        issue(0, 0, 64'h10, 2'd3, 0, 64'h0, 64'h1122334455667788, 0, 1, a1);
        // byte store and sign/zero extension
        issue(0, 1, 64'h13, 2'd0, 0, 64'h80, 64'h0, 0, 0, a1);
        issue(0, 0, 64'h13, 2'd0, 0, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 0, a1);
        issue(0, 0, 64'h13, 2'd0, 1, 64'h0, 64'h80, 0, 0, a1);
        issue(0, 0, 64'h10, 2'd3, 0, 64'h0, 64'h1122334480667788, 0, 0, a1);
        issue(0, 0, 64'h12, 2'd1, 0, 64'h0, 64'hFFFFFFFFFFFF8066, 0, 0, a1);
        issue(0, 0, 64'h14, 2'd2, 1, 64'h0, 64'h11223344, 0, 0, a1);
`ifdef YSYX_DMEM_ERR_EN
        issue(0, 0, 64'h11, 2'd1, 0, 64'h0, 64'h0, 1, 0, a1);
        issue(0, 1, 64'h1010, 2'd0, 0, 64'hEE, 64'h0, 1, 0, a1);
        issue(0, 0, 64'h10, 2'd3, 0, 64'h0, 64'h1122334480667788, 0, 0, a1);
`else
        issue(0, 0, 64'h11, 2'd1, 0, 64'h0, 64'h7788, 0, 0, a1);
        issue(0, 1, 64'h1010, 2'd0, 0, 64'hEE, 64'h0, 0, 0, a1);
        issue(0, 0, 64'h10, 2'd3, 0, 64'h0, 64'h11223344806677EE, 0, 0, a1);
`endif
        issue(0, 1, 64'h18, 2'd2, 0, 64'hDEADBEEF, 64'h0, 0, 0, a1);
        issue(0, 0, 64'h18, 2'd2, 0, 64'h0, 64'hFFFFFFFFDEADBEEF, 0, 0, a1);
        drain();
        // back-pressure on the response channel
        rsp_ready = 1'b0;
        issue(0, 0, 64'h18, 2'd2, 1, 64'h0, 64'hDEADBEEF, 0, 0, a1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld0 && n < 20);
        chk("bp_valid_seen", {63'd0, vld0}, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", {63'd0, vld0}, 1);
            chk("bp_hold_rdata", rd0, 64'hDEADBEEF);
            chk("bp_req_ready_low", {63'd0, rdy0}, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_req_ready_back", {63'd0, rdy0}, 1);
        chk("bp_valid_drop", {63'd0, vld0}, 0);
        drain();
        // reset during the wait of a store drops it
        issue(0, 1, 64'h20, 2'd0, 0, 64'h5A, 64'h0, 0, 0, a1);
        issue(0, 0, 64'h20, 2'd0, 1, 64'h0, 64'h5A, 0, 0, a1);
        drain();
        issue(0, 1, 64'h20, 2'd0, 0, 64'hAA, 64'h0, 0, 0, a1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", {63'd0, rdy0}, 1);
        chk("mid_rst_rsp_valid", {63'd0, vld0}, 0);
        chk("mid_rst_rdata", rd0, 0);
        chk("mid_rst_err", {63'd0, err0}, 0);
        q0.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 0, 64'h20, 2'd0, 1, 64'h0, 64'h5A, 0, 0, a1);
        drain();
        // zero-latency instance, back-to-back
        issue(1, 1, 64'h40, 2'd2, 0, 64'hCAFEBABE, 64'h0, 0, 1, a1);
        issue(1, 0, 64'h40, 2'd2, 1, 64'h0, 64'hCAFEBABE, 0, 1, a2);
        issue(1, 0, 64'h42, 2'd1, 0, 64'h0, 64'hFFFFFFFFFFFFCAFE, 0, 1, a3);
        chk("l0_spacing_a", 64'(a2 - a1), 2);
        chk("l0_spacing_b", 64'(a3 - a2), 2);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
